// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int REG_AW_MAX = 8;
    localparam int REG_ZERO   = 0;
    localparam int FWD_RF     = 0;
    localparam int STAGE_EXE  = 0;
    localparam int STAGE_MEM  = 1;
    localparam int STAGE_WB   = 2;

    // dest is sized for the widest supported register file and zero-extended on entry
    typedef struct packed {
        logic                  v;
        logic                  wreg;
        logic                  m2reg;
        logic [REG_AW_MAX-1:0] dest;
    } hazard_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-side bundle between the decode stage and the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
) ();
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wreg;
    logic              id_m2reg;
    logic [REG_AW-1:0] id_dest;
    logic              flush;
    logic              stall;
    logic              id_kill;
    logic [FWD_W-1:0]  fwd_a;
    logic [FWD_W-1:0]  fwd_b;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_dest, flush,
        input  stall, id_kill, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_dest, flush,
        output stall, id_kill, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_match.sv
// Combinational youngest-producer search for one source operand.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int IDX_W      = 2
) (
    input  hazard_entry_t [NUM_STAGES-1:0] entries_i,
    input  logic [REG_AW-1:0]              reg_i,
    input  logic                           use_i,
    output logic                           hit_o,
    output logic [IDX_W-1:0]               idx_o,
    output logic                           load_o
);
    logic [NUM_STAGES-1:0] match;
    logic [REG_AW_MAX-1:0] reg_ext;

    assign reg_ext = REG_AW_MAX'(reg_i);

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
        assign match[gi] = entries_i[gi].v & entries_i[gi].wreg & use_i &
                           (entries_i[gi].dest == reg_ext) &
                           (reg_ext != REG_AW_MAX'(REG_ZERO));
    end

    // Scan oldest to youngest so the youngest hit is the one left standing.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        load_o = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o  = 1'b1;
                idx_o  = IDX_W'(i);
                load_o = entries_i[i].m2reg;
            end
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: tracks in-flight writers and drives fwd selects, stall and kill.
// Optional stall counter (perf_stalls/perf_clr) is built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_STAGE = STAGE_MEM,
    parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_stalls
`endif
);
    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] LOAD_IDX = IDX_W'(LOAD_STAGE);

    if (NUM_STAGES < 2 || NUM_STAGES > 6 || LOAD_STAGE < 0 ||
        LOAD_STAGE >= NUM_STAGES || REG_AW > REG_AW_MAX) begin : g_bad_cfg
        $error("pipeline_hazard_ctrl: unsupported parameter combination");
    end

    hazard_entry_t [NUM_STAGES-1:0] entries_q;
    hazard_entry_t [NUM_STAGES-1:0] entries_d;

    logic             hit_a, hit_b, load_a, load_b;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic             stall_a, stall_b, stall_raw;

    hazard_match #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .IDX_W(IDX_W)) u_match_rs (
        .entries_i (entries_q),
        .reg_i     (bus.id_rs),
        .use_i     (bus.id_valid & bus.id_use_rs),
        .hit_o     (hit_a),
        .idx_o     (idx_a),
        .load_o    (load_a)
    );

    hazard_match #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .IDX_W(IDX_W)) u_match_rt (
        .entries_i (entries_q),
        .reg_i     (bus.id_rt),
        .use_i     (bus.id_valid & bus.id_use_rt),
        .hit_o     (hit_b),
        .idx_o     (idx_b),
        .load_o    (load_b)
    );

    // A load is only forwardable once it has reached LOAD_STAGE; anything younger must wait.
    assign stall_a   = hit_a & load_a & (idx_a < LOAD_IDX);
    assign stall_b   = hit_b & load_b & (idx_b < LOAD_IDX);
    assign stall_raw = stall_a | stall_b;

    assign bus.stall   = stall_raw & ~bus.flush;
    assign bus.id_kill = stall_raw | bus.flush;
    assign bus.fwd_a   = hit_a ? FWD_W'(idx_a) + FWD_W'(1) : FWD_W'(FWD_RF);
    assign bus.fwd_b   = hit_b ? FWD_W'(idx_b) + FWD_W'(1) : FWD_W'(FWD_RF);

    assign entries_d[0] = '{
        v:     bus.id_valid & ~bus.id_kill,
        wreg:  bus.id_wreg,
        m2reg: bus.id_m2reg,
        dest:  REG_AW_MAX'(bus.id_dest)
    };

    for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_shift
        assign entries_d[gi] = entries_q[gi-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (bus.stall && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stalls = perf_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pipeline_hazard_ctrl;
    localparam int NS = 3;
    localparam int LS = 1;
    localparam int AW = 5;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(AW), .FWD_W(FW)) bus ();

`ifdef HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_stalls;
    longint      mperf = 0;
`endif

    pipeline_hazard_ctrl #(.REG_AW(AW), .NUM_STAGES(NS), .LOAD_STAGE(LS), .FWD_W(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HAZARD_PERF_EN
        ,
        .perf_clr    (perf_clr),
        .perf_stalls (perf_stalls)
`endif
    );

    typedef struct {
        bit v;
        bit wreg;
        bit m2reg;
        int dest;
    } ent_t;

    ent_t m[NS];   // m[k] = instruction k+1 cycles past ID
    int checks = 0;
    int fails  = 0;

    // Reference: youngest in-flight writer of r wins; a load younger than LS cannot be forwarded yet.
    function automatic void ref_op(input logic [AW-1:0] r, input logic u, output int fwd, output bit st);
        fwd = 0;
        st  = 1'b0;
        if (!bus.id_valid || !u || r == 0) return;
        for (int k = 0; k < NS; k++) begin
            if (m[k].v && m[k].wreg && m[k].dest == int'(r)) begin
                fwd = k + 1;
                st  = m[k].m2reg && (k < LS);
                return;
            end
        end
    endfunction

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic urs,
                          input logic [AW-1:0] rt, input logic urt, input logic w,
                          input logic ld, input logic [AW-1:0] d, input logic fl);
        bus.id_valid  = v;
        bus.id_rs     = rs;
        bus.id_use_rs = urs;
        bus.id_rt     = rt;
        bus.id_use_rt = urt;
        bus.id_wreg   = w;
        bus.id_m2reg  = ld;
        bus.id_dest   = d;
        bus.flush     = fl;
        #1;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        int  fa, fb;
        bit  sa, sb, kill;
        ref_op(bus.id_rs, bus.id_use_rs, fa, sa);
        ref_op(bus.id_rt, bus.id_use_rt, fb, sb);
        kill = sa | sb | bus.flush;
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) m[k] = '{0, 0, 0, 0};
        end else begin
            for (int k = NS - 1; k > 0; k--) m[k] = m[k-1];
            m[0] = '{bus.id_valid && !kill, bus.id_wreg, bus.id_m2reg, int'(bus.id_dest)};
        end
`ifdef HAZARD_PERF_EN
        if (!rst_n || perf_clr) mperf = 0;
        else if ((sa || sb) && !bus.flush && mperf != 64'hFFFF_FFFF) mperf++;
`endif
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (NS) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        set_id(1, 3, 1, 3, 1, 1, 0, 3, 0);
        $display("[reset] stall=%0b kill=%0b fwd_a=%0d fwd_b=%0d", bus.stall, bus.id_kill, bus.fwd_a, bus.fwd_b);
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
        checks++; if (bus.id_kill !== 1'b0) begin fails++; $display("FAIL reset_kill got=%0b exp=0", bus.id_kill); end
        checks++; if (bus.fwd_a !== 2'd0) begin fails++; $display("FAIL reset_fwd_a got=%0d exp=0", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'd0) begin fails++; $display("FAIL reset_fwd_b got=%0d exp=0", bus.fwd_b); end
`ifdef HAZARD_PERF_EN
        checks++; if (perf_stalls !== 32'd0) begin fails++; $display("FAIL reset_perf got=%0d exp=0", perf_stalls); end
`endif
        idle();
        tick();
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_alu_fwd();
        set_id(1, 0, 0, 0, 0, 1, 0, 3, 0);
        tick();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        $display("[alu] rs=3 behind add: fwd_a=%0d stall=%0b", bus.fwd_a, bus.stall);
        checks++; if (bus.fwd_a !== 2'd1) begin fails++; $display("FAIL alu_exe_fwd got=%0d exp=1", bus.fwd_a); end
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL alu_exe_stall got=%0b exp=0", bus.stall); end
        tick();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        $display("[alu] rs=3 one gap: fwd_a=%0d", bus.fwd_a);
        checks++; if (bus.fwd_a !== 2'd2) begin fails++; $display("FAIL alu_mem_fwd got=%0d exp=2", bus.fwd_a); end
        tick();
        set_id(1, 0, 0, 3, 1, 0, 0, 0, 0);
        $display("[alu] rt=3 two gaps: fwd_b=%0d", bus.fwd_b);
        checks++; if (bus.fwd_b !== 2'd3) begin fails++; $display("FAIL alu_wb_fwd got=%0d exp=3", bus.fwd_b); end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 0, 1, 1, 5, 0);
        tick();
        set_id(1, 9, 1, 5, 1, 1, 0, 9, 0);
        $display("[load] consumer rt=5 after lw: stall=%0b kill=%0b", bus.stall, bus.id_kill);
        checks++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL load_stall got=%0b exp=1", bus.stall); end
        checks++; if (bus.id_kill !== 1'b1) begin fails++; $display("FAIL load_kill got=%0b exp=1", bus.id_kill); end
        tick();
        $display("[load] retry: stall=%0b fwd_b=%0d fwd_a=%0d", bus.stall, bus.fwd_b, bus.fwd_a);
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_stall_once got=%0b exp=0", bus.stall); end
        checks++; if (bus.fwd_b !== 2'd2) begin fails++; $display("FAIL load_fwd_mem got=%0d exp=2", bus.fwd_b); end
        checks++; if (bus.fwd_a !== 2'd0) begin fails++; $display("FAIL load_bubble got=%0d exp=0", bus.fwd_a); end
        tick();
        drain();
    endtask

    task automatic test_reg_zero();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        $display("[r0] fwd_a=%0d fwd_b=%0d stall=%0b", bus.fwd_a, bus.fwd_b, bus.stall);
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL r0_stall got=%0b exp=0", bus.stall); end
        checks++; if (bus.fwd_a !== 2'd0) begin fails++; $display("FAIL r0_fwd_a got=%0d exp=0", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'd0) begin fails++; $display("FAIL r0_fwd_b got=%0d exp=0", bus.fwd_b); end
        tick();
        drain();
    endtask

    task automatic test_priority();
        set_id(1, 0, 0, 0, 0, 1, 0, 7, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 0, 7, 0);
        tick();
        set_id(1, 7, 1, 7, 1, 0, 0, 0, 0);
        $display("[prio] fwd_a=%0d fwd_b=%0d", bus.fwd_a, bus.fwd_b);
        checks++; if (bus.fwd_a !== 2'd1) begin fails++; $display("FAIL prio_fwd_a got=%0d exp=1", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'd1) begin fails++; $display("FAIL prio_fwd_b got=%0d exp=1", bus.fwd_b); end
        tick();
        drain();
    endtask

    task automatic test_flush();
        set_id(1, 0, 0, 0, 0, 1, 1, 4, 0);
        tick();
        set_id(1, 4, 1, 0, 0, 1, 0, 4, 1);
        $display("[flush] stall=%0b kill=%0b", bus.stall, bus.id_kill);
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_stall got=%0b exp=0", bus.stall); end
        checks++; if (bus.id_kill !== 1'b1) begin fails++; $display("FAIL flush_kill got=%0b exp=1", bus.id_kill); end
        tick();
        set_id(1, 0, 0, 4, 1, 0, 0, 0, 0);
        $display("[flush] next rt=4: fwd_b=%0d stall=%0b", bus.fwd_b, bus.stall);
        checks++; if (bus.fwd_b !== 2'd2) begin fails++; $display("FAIL flush_bubble got=%0d exp=2", bus.fwd_b); end
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_after_stall got=%0b exp=0", bus.stall); end
        tick();
        drain();
    endtask

    task automatic test_reset_midflight();
        set_id(1, 0, 0, 0, 0, 1, 0, 10, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 1, 11, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 0, 12, 0);
        tick();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        set_id(1, 10, 1, 11, 1, 0, 0, 0, 0);
        $display("[midrst] fwd_a=%0d fwd_b=%0d stall=%0b", bus.fwd_a, bus.fwd_b, bus.stall);
        checks++; if (bus.fwd_a !== 2'd0) begin fails++; $display("FAIL midrst_fwd_a got=%0d exp=0", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'd0) begin fails++; $display("FAIL midrst_fwd_b got=%0d exp=0", bus.fwd_b); end
        checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL midrst_stall got=%0b exp=0", bus.stall); end
        set_id(1, 12, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.fwd_a !== 2'd0) begin fails++; $display("FAIL midrst_fwd_wb got=%0d exp=0", bus.fwd_a); end
`ifdef HAZARD_PERF_EN
        checks++; if (perf_stalls !== 32'd0) begin fails++; $display("FAIL midrst_perf got=%0d exp=0", perf_stalls); end
        tick();
        for (int n = 0; n < 2; n++) begin
            set_id(1, 0, 0, 0, 0, 1, 1, AW'(13 + n), 0);
            tick();
            set_id(1, AW'(13 + n), 1, 0, 0, 0, 0, 0, 0);
            tick();
            tick();
            drain();
        end
        $display("[perf] perf_stalls=%0d", perf_stalls);
        checks++; if (perf_stalls !== 32'd2) begin fails++; $display("FAIL perf_two got=%0d exp=2", perf_stalls); end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        checks++; if (perf_stalls !== 32'd0) begin fails++; $display("FAIL perf_clr got=%0d exp=0", perf_stalls); end
`endif
        tick();
        drain();
    endtask

    task automatic test_random();
        int  ea, eb;
        bit  sa, sb, est, ekill;
        logic fl;
        for (int n = 0; n < 300; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
`ifdef HAZARD_PERF_EN
            perf_clr = ($urandom_range(0, 39) == 0);
`endif
            fl = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), fl);
            ref_op(bus.id_rs, bus.id_use_rs, ea, sa);
            ref_op(bus.id_rt, bus.id_use_rt, eb, sb);
            est   = (sa | sb) & !fl;
            ekill = sa | sb | fl;
            $display("[rand %0d] v=%0b rs=%0d rt=%0d fl=%0b stall=%0b/%0b kill=%0b/%0b fa=%0d/%0d fb=%0d/%0d",
                     n, bus.id_valid, bus.id_rs, bus.id_rt, fl, bus.stall, est, bus.id_kill, ekill,
                     bus.fwd_a, ea, bus.fwd_b, eb);
            checks++; if (bus.stall !== est) begin fails++; $display("FAIL rand_stall n=%0d got=%0b exp=%0b", n, bus.stall, est); end
            checks++; if (bus.id_kill !== ekill) begin fails++; $display("FAIL rand_kill n=%0d got=%0b exp=%0b", n, bus.id_kill, ekill); end
            if (!sa) begin
                checks++; if (bus.fwd_a !== FW'(ea)) begin fails++; $display("FAIL rand_fwd_a n=%0d got=%0d exp=%0d", n, bus.fwd_a, ea); end
            end
            if (!sb) begin
                checks++; if (bus.fwd_b !== FW'(eb)) begin fails++; $display("FAIL rand_fwd_b n=%0d got=%0d exp=%0d", n, bus.fwd_b, eb); end
            end
            tick();
        end
        rst_n = 1'b1;
`ifdef HAZARD_PERF_EN
        perf_clr = 1'b0;
        checks++; if (perf_stalls !== 32'(mperf)) begin fails++; $display("FAIL rand_perf got=%0d exp=%0d", perf_stalls, mperf); end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_reg_zero();
        test_priority();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS datapath; generalises the fixed 5-stage IF/ID/EXE/MEM/WB chain to NUM_STAGES tracked post-ID stages.
- Keeps a shadow shift register of destination and write/load flags for every in-flight instruction past ID.
- Produces per-operand forwarding selects, load-use stall and ID flush/bubble control.
- Sits beside ID: it is fed by ControlUnit and the rs/rt/dest fields, and it drives the operand muxes feeding ID_EXE and the IF/ID hold enable.

Parameters:
- REG_AW, 5: register address width (32-entry file).
- NUM_STAGES, 3: tracked stages after ID (index 0 = EXE, 1 = MEM, 2 = WB); legal range 2..6.
- LOAD_STAGE, 1: stage index at which load data becomes forwardable (1 = MEM output).
- FWD_W, $clog2(NUM_STAGES+1): width of the forward select.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source A register
- id_rt  in  REG_AW  source B register
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wreg  in  1  instruction writes the register file (ControlUnit wreg)
- id_m2reg  in  1  instruction is a load (ControlUnit m2reg)
- id_dest  in  REG_AW  destination register (rd_rt mux output)
- flush  in  1  redirect (taken branch/jump): squash ID
- stall  out  1  hold PC and IF/ID; insert bubble into EXE
- id_kill  out  1  ID instruction must not enter EXE (stall | flush)
- fwd_a  out  FWD_W  0 = register file, k = stage k-1 result
- fwd_b  out  FWD_W  same, for operand B

Behaviour:
- Tracking entry per stage: {v, wreg, m2reg, dest}. On reset, every entry is cleared to zero. Resulting output values: stall=0, id_kill=0, fwd_a=fwd_b=0.
- Shift rule each clk while rst_n=1:
  - Entry[i] <= entry[i-1] for i ≥ 1.
  - Entry[0] <= {id_valid & ~id_kill, id_wreg, id_m2reg, id_dest}.
  - When id_kill=1, entry[0].v is forced to 0 (bubble).
- Match[i] for an operand = v & wreg & (dest == reg) & (reg != 0) & use. Register 0 is never forwarded and never stalls.
- Forward select: for the lowest i with match[i], fwd = i+1, giving priority to the youngest producer. If there is no match, fwd = 0. fwd_a and fwd_b are combinational from the entries and the ID inputs; they take effect in the same cycle as the ID inputs.
- Load-use stall:
  - stall=1 when the youngest matching entry i has m2reg=1 and i < LOAD_STAGE.
  - While stall=1, the fwd outputs for that operand are don't-care.
  - Evaluated per operand; stall is the OR of both operands.
- Stall repetition: for a load still short of LOAD_STAGE, stall repeats each cycle until the producer reaches LOAD_STAGE. With default parameters, a load immediately followed by a dependent instruction stalls exactly 1 cycle.
- Flush:
  - flush=1 forces id_kill=1 and stall=0 (flush overrides stall).
  - The ID instruction becomes a bubble; older entries continue shifting unaffected.
- id_valid=0: no match is computed, stall=0, and a bubble enters entry[0].
- Reset mid-operation: all in-flight entries are discarded on the next edge. No forwarding occurs from pre-reset instructions.
- Oldest entry (index NUM_STAGES-1, the WB stage): forwarding from it is still needed because the register file writes on the same edge that ID reads.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds output perf_stalls (32 bits) and input perf_clr (1 bit).
  - perf_stalls increments on each cycle with stall=1 and flush=0. It saturates at 0xFFFFFFFF.
  - perf_stalls is cleared by rst_n=0 or perf_clr=1; clear wins over increment.
- When undefined: the ports and the counter are absent, with no logic cost.

Decomposition:
- Shared package pipe_pkg:
  - Struct hazard_entry_t {v, wreg, m2reg, dest}.
  - Localparams REG_ZERO, FWD_RF=0, STAGE_EXE=0, STAGE_MEM=1, STAGE_WB=2.
- One natural sub-module: hazard_match. It is combinational: it takes the entry array, reg and use, and returns the youngest-match index plus its load flag. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Back-to-back ALU dependency: add r3 (wreg, dest=3), then next cycle ID rs=3 -> fwd_a=1, stall=0. One cycle later, with an unrelated instruction in between, the same rs=3 -> fwd_a=2.
- Load-use: lw dest=5 (m2reg), next ID rt=5 -> stall=1 for exactly 1 cycle, entry[0].v=0 bubble. The following cycle -> stall=0, fwd_b=2.
- Register 0: producer dest=0 with wreg=1, consumer rs=0 -> fwd_a=0, stall=0, even when the producer is a load.
- Priority: dest=7 in both EXE and MEM, consumer rs=7, rt=7 -> fwd_a=fwd_b=1.
- Flush during stall: load dest=4, consumer rs=4 with flush=1 -> stall=0, id_kill=1; the next cycle entry[0].v=0, while the load continues into MEM.
- Reset mid-flight: three producers in flight, rst_n=0 for 1 cycle, then consumer rs of any of those dests -> fwd_a=0, stall=0. With HAZARD_PERF_EN, perf_stalls reads 0 after reset and 2 after two load-use stalls.
